// File: rtl/alu_logic_arbiter_if.sv
// alu_logic_arbiter_if: request/response bundle for the two-requester logic unit
interface alu_logic_arbiter_if #(parameter int WIDTH = 32);
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic [15:0]      ops_done;
    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, ops_done
    );
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, ops_done
    );
endinterface

// File: rtl/alu_logic_arbiter.sv
// alu_logic_arbiter: round-robin sharing of one bitwise logic unit with a single-entry result buffer
module alu_logic_arbiter #(
    parameter int WIDTH = 32
) (
    input logic                clk,
    input logic                rst_n,
    alu_logic_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           r_state, w_state_next;
    logic             r_last_gnt, r_id;
    logic [WIDTH-1:0] r_data;
    logic [15:0]      r_ops_done;
    logic             w_slot_free, w_gnt_id, w_accept, w_deliver;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a, w_b, w_result;

    // grant from valids and pointer only, so readiness never depends on op or operands
    always_comb begin
        w_slot_free  = (r_state == EMPTY) || bus.rsp_ready;
        w_gnt_id     = (bus.req0_valid && bus.req1_valid) ? ~r_last_gnt : bus.req1_valid;
        w_accept     = rst_n && (bus.req0_valid || bus.req1_valid) && w_slot_free;
        w_deliver    = (r_state == FULL) && bus.rsp_ready;
        w_state_next = w_accept ? FULL : (w_deliver ? EMPTY : r_state);
    end

    // operand select and the shared logic unit
    always_comb begin
        w_op     = w_gnt_id ? bus.req1_op : bus.req0_op;
        w_a      = w_gnt_id ? bus.req1_a : bus.req0_a;
        w_b      = w_gnt_id ? bus.req1_b : bus.req0_b;
        w_result = (w_op == 2'b00) ? (w_a & w_b) :
                   (w_op == 2'b01) ? (w_a | w_b) :
                   (w_op == 2'b10) ? (w_a ^ w_b) : ~(w_a | w_b);
    end

    // buffer occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_next;
    end

    // result, owner, round-robin pointer and delivery count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_id       <= 1'b0;
            r_last_gnt <= 1'b1;
            r_ops_done <= 16'd0;
        end else begin
            if (w_accept) begin
                r_data     <= w_result;
                r_id       <= w_gnt_id;
                r_last_gnt <= w_gnt_id;
            end
            if (w_deliver) r_ops_done <= r_ops_done + 16'd1;
        end
    end

    assign bus.req0_ready = w_accept && !w_gnt_id;
    assign bus.req1_ready = w_accept && w_gnt_id;
    assign bus.rsp_valid  = (r_state == FULL);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_data   = r_data;
    assign bus.ops_done   = r_ops_done;
endmodule
